// File: rtl/jop_ddr3_bridge.sv
// ----------------------------------------------------------------------------
// jop_ddr3_bridge
//
// Connects the JOP memory controller's 32-bit word port to the Xilinx MIG
// 7-series native UI (128-bit lines, BL8, x16 DDR3). It runs entirely in the
// MIG ui_clk domain and issues one MIG transaction per JOP access. No traffic
// is accepted until DDR3 calibration has completed.
//
// Word w of a 128-bit line occupies bits [32w+31:32w] (little-endian order).
// The lane is selected by the two low bits of the JOP word address.
//
// Optional feature, enabled by defining JOP_DDR3_LINE_CACHE_EN:
//   A single-line read buffer holds the last line read from the MIG.
//   A read that hits this line is answered locally without a MIG access.
//   A write that hits it merges its word into the buffer and still goes to
//   the MIG (write-through).
//
// Ports
//   clk               ui_clk, the only clock
//   resetn            synchronous active-low reset
//   calib_done        MIG init_calib_complete
//   rd / wr           one-cycle request strobes (wr wins if both are high)
//   addr              JOP word address
//   wr_data           word to write
//   rd_data           last read result, held until the next read completes
//   done              one-cycle completion pulse
//   busy              high while no new request can be accepted
//   app_en/cmd/addr   MIG command channel, app_rdy accepts
//   app_wdf_*         MIG write-data channel, app_wdf_rdy accepts
//   app_rd_data*      MIG read-data return
// ----------------------------------------------------------------------------
module jop_ddr3_bridge #(
    parameter int ADDR_W     = 26,
    parameter int APP_ADDR_W = 28
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  calib_done,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    output logic                  done,
    output logic                  busy,
    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [APP_ADDR_W-1:0] app_addr,
    input  logic                  app_rdy,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [127:0]          app_wdf_data,
    output logic [15:0]           app_wdf_mask,
    input  logic                  app_wdf_rdy,
    input  logic                  app_rd_data_valid,
    input  logic                  app_rd_data_end,
    input  logic [127:0]          app_rd_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3
`ifdef JOP_DDR3_LINE_CACHE_EN
        ,
        RD_HIT  = 3'd4
`endif
    } state_e;

    state_e                  state_q, state_d;
    logic [APP_ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]              lane_q, lane_d;
    logic [127:0]            wdata_q, wdata_d;
    logic [15:0]             mask_q, mask_d;
    logic                    cmd_ok_q, cmd_ok_d;
    logic                    dat_ok_q, dat_ok_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    done_q, done_d;

`ifdef JOP_DDR3_LINE_CACHE_EN
    logic [127:0]            line_q, line_d;
    logic [APP_ADDR_W-5:0]   tag_q, tag_d;
    logic                    valid_q, valid_d;
    logic                    hit;
`endif

    logic [APP_ADDR_W-1:0]   byte_addr;
    logic [APP_ADDR_W-1:0]   line_addr;
    logic [1:0]              req_lane;
    logic [15:0]             req_mask;
    logic [31:0]             lane_word;
    logic                    unused_ok;

    // The MIG addresses bytes; a 128-bit line spans 16 bytes, so the low
    // nibble of the line address is always zero.
    assign byte_addr = APP_ADDR_W'({addr, 2'b00});
    assign line_addr = {byte_addr[APP_ADDR_W-1:4], 4'b0000};
    assign req_lane  = addr[1:0];
    assign req_mask  = ~(16'h000F << {req_lane, 2'b00});
    assign lane_word = app_rd_data[{lane_q, 5'b00000} +: 32];

    // With one beat per burst app_rd_data_end carries no information.
    assign unused_ok = ^{app_rd_data_end, byte_addr[3:0]};

`ifdef JOP_DDR3_LINE_CACHE_EN
    assign hit = valid_q && (tag_q == byte_addr[APP_ADDR_W-1:4]);
`endif

    // State register: synchronous reset aborts any operation on the spot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            lane_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            cmd_ok_q  <= 1'b0;
            dat_ok_q  <= 1'b0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
`ifdef JOP_DDR3_LINE_CACHE_EN
            line_q    <= '0;
            tag_q     <= '0;
            valid_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lane_q    <= lane_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            cmd_ok_q  <= cmd_ok_d;
            dat_ok_q  <= dat_ok_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
`ifdef JOP_DDR3_LINE_CACHE_EN
            line_q    <= line_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
`endif
        end
    end

    // Next-state logic. The command and write-data channels of a write are
    // tracked independently because the MIG may accept them in any order.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lane_d    = lane_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        cmd_ok_d  = cmd_ok_q;
        dat_ok_d  = dat_ok_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
`ifdef JOP_DDR3_LINE_CACHE_EN
        line_d    = line_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (calib_done) begin
                    if (wr) begin
                        addr_d   = line_addr;
                        lane_d   = req_lane;
                        wdata_d  = {4{wr_data}};
                        mask_d   = req_mask;
                        cmd_ok_d = 1'b0;
                        dat_ok_d = 1'b0;
                        state_d  = WR;
`ifdef JOP_DDR3_LINE_CACHE_EN
                        if (hit) begin
                            for (int i = 0; i < 4; i++) begin
                                if (req_lane == 2'(i)) begin
                                    line_d[32*i +: 32] = wr_data;
                                end
                            end
                        end
`endif
                    end else if (rd) begin
                        addr_d  = line_addr;
                        lane_d  = req_lane;
`ifdef JOP_DDR3_LINE_CACHE_EN
                        state_d = hit ? RD_HIT : RD_CMD;
`else
                        state_d = RD_CMD;
`endif
                    end
                end
            end
            RD_CMD: begin
                if (app_rdy) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid) begin
                    rd_data_d = lane_word;
                    done_d    = 1'b1;
                    state_d   = IDLE;
`ifdef JOP_DDR3_LINE_CACHE_EN
                    line_d    = app_rd_data;
                    tag_d     = addr_q[APP_ADDR_W-1:4];
                    valid_d   = 1'b1;
`endif
                end
            end
            WR: begin
                cmd_ok_d = cmd_ok_q | app_rdy;
                dat_ok_d = dat_ok_q | app_wdf_rdy;
                if ((cmd_ok_q | app_rdy) && (dat_ok_q | app_wdf_rdy)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef JOP_DDR3_LINE_CACHE_EN
            RD_HIT: begin
                rd_data_d = line_q[{lane_q, 5'b00000} +: 32];
                done_d    = 1'b1;
                state_d   = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. The strobes come straight from state so that a reset
    // drops them on the same edge that returns the state to IDLE.
    always_comb begin
        app_en       = 1'b0;
        app_cmd      = 3'b000;
        app_wdf_wren = 1'b0;
        case (state_q)
            RD_CMD: begin
                app_en  = 1'b1;
                app_cmd = 3'b001;
            end
            WR: begin
                app_en       = ~cmd_ok_q;
                app_wdf_wren = ~dat_ok_q;
            end
            default: begin
                app_en       = 1'b0;
            end
        endcase
        busy = (state_q != IDLE) | ~calib_done | ~resetn;
    end

    assign app_wdf_end  = app_wdf_wren;
    assign app_addr     = addr_q;
    assign app_wdf_data = wdata_q;
    assign app_wdf_mask = mask_q;
    assign rd_data      = rd_data_q;
    assign done         = done_q;

endmodule

// File: tb/tb_jop_ddr3_bridge.sv
// ----------------------------------------------------------------------------
// tb_jop_ddr3_bridge
//
// Directed bench for jop_ddr3_bridge. A transaction-level model tracks what
// the bridge owes the JOP side and the MIG side; a compare process checks the
// DUT against it on every falling edge, and the directed sequence adds
// hand-computed literal checks at the interesting points.
// ----------------------------------------------------------------------------
module tb_jop_ddr3_bridge;

    localparam int ADDR_W     = 26;
    localparam int APP_ADDR_W = 28;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic                  calibDone = 1'b1;
    logic                  rd = 1'b0;
    logic                  wr = 1'b0;
    logic [ADDR_W-1:0]     addr = '0;
    logic [31:0]           wrData = '0;
    logic [31:0]           rdData;
    logic                  done;
    logic                  busy;
    logic                  appEn;
    logic [2:0]            appCmd;
    logic [APP_ADDR_W-1:0] appAddr;
    logic                  appRdy = 1'b0;
    logic                  appWdfWren;
    logic                  appWdfEnd;
    logic [127:0]          appWdfData;
    logic [15:0]           appWdfMask;
    logic                  appWdfRdy = 1'b0;
    logic                  appRdDataValid = 1'b0;
    logic                  appRdDataEnd = 1'b0;
    logic [127:0]          appRdData = '0;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    jop_ddr3_bridge #(.ADDR_W(ADDR_W), .APP_ADDR_W(APP_ADDR_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .calib_done        (calibDone),
        .rd                (rd),
        .wr                (wr),
        .addr              (addr),
        .wr_data           (wrData),
        .rd_data           (rdData),
        .done              (done),
        .busy              (busy),
        .app_en            (appEn),
        .app_cmd           (appCmd),
        .app_addr          (appAddr),
        .app_rdy           (appRdy),
        .app_wdf_wren      (appWdfWren),
        .app_wdf_end       (appWdfEnd),
        .app_wdf_data      (appWdfData),
        .app_wdf_mask      (appWdfMask),
        .app_wdf_rdy       (appWdfRdy),
        .app_rd_data_valid (appRdDataValid),
        .app_rd_data_end   (appRdDataEnd),
        .app_rd_data       (appRdData)
    );

    always #5 clk = ~clk;

    // Transaction model: one outstanding access, with independent pending
    // flags for the command and the write data.
    typedef enum {OP_NONE, OP_READ, OP_WRITE} op_e;
    op_e         mOp = OP_NONE;
    bit          mCmdPend = 1'b0;
    bit          mDatPend = 1'b0;
    bit          mDone = 1'b0;
    logic [27:0] mAddr = '0;
    logic [1:0]  mLane = '0;
    logic [127:0] mData = '0;
    logic [15:0] mMask = '0;
    logic [31:0] mRdData = '0;

    function automatic logic [15:0] maskFor(input logic [1:0] lane);
        logic [15:0] m;
        for (int b = 0; b < 16; b++) begin
            m[b] = ((b / 4) != int'(lane));
        end
        return m;
    endfunction

    function automatic logic [31:0] wordOf(input logic [127:0] line, input logic [1:0] lane);
        return 32'(line >> (32 * int'(lane)));
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            mOp      <= OP_NONE;
            mCmdPend <= 1'b0;
            mDatPend <= 1'b0;
            mDone    <= 1'b0;
            mRdData  <= '0;
        end else begin
            mDone <= 1'b0;
            case (mOp)
                OP_NONE: begin
                    if (calibDone && (wr || rd)) begin
                        mAddr    <= ({2'b00, addr} * 28'd4) & 28'hFFFFFF0;
                        mLane    <= addr[1:0];
                        mCmdPend <= 1'b1;
                        if (wr) begin
                            mOp      <= OP_WRITE;
                            mDatPend <= 1'b1;
                            mData    <= {wrData, wrData, wrData, wrData};
                            mMask    <= maskFor(addr[1:0]);
                        end else begin
                            mOp <= OP_READ;
                        end
                    end
                end
                OP_READ: begin
                    if (mCmdPend) begin
                        if (appRdy) mCmdPend <= 1'b0;
                    end else if (appRdDataValid) begin
                        mRdData <= wordOf(appRdData, mLane);
                        mDone   <= 1'b1;
                        mOp     <= OP_NONE;
                    end
                end
                OP_WRITE: begin
                    if (appRdy) mCmdPend <= 1'b0;
                    if (appWdfRdy) mDatPend <= 1'b0;
                    if ((!mCmdPend || appRdy) && (!mDatPend || appWdfRdy)) begin
                        mDone <= 1'b1;
                        mOp   <= OP_NONE;
                    end
                end
                default: mOp <= OP_NONE;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: every falling edge, against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            logic expBusy, expEn, expWren;
            expBusy = (mOp != OP_NONE) || !calibDone || !resetn;
            expEn   = (mOp != OP_NONE) && mCmdPend;
            expWren = (mOp == OP_WRITE) && mDatPend;
            checkOutput("busy", 128'(busy), 128'(expBusy));
            checkOutput("app_en", 128'(appEn), 128'(expEn));
            checkOutput("app_wdf_wren", 128'(appWdfWren), 128'(expWren));
            checkOutput("app_wdf_end", 128'(appWdfEnd), 128'(expWren));
            checkOutput("done", 128'(done), 128'(mDone));
            checkOutput("rd_data", 128'(rdData), 128'(mRdData));
            if (expEn) begin
                checkOutput("app_cmd", 128'(appCmd), (mOp == OP_READ) ? 128'd1 : 128'd0);
                checkOutput("app_addr", 128'(appAddr), 128'(mAddr));
            end
            if (expWren) begin
                checkOutput("app_wdf_data", appWdfData, mData);
                checkOutput("app_wdf_mask", 128'(appWdfMask), 128'(mMask));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        repeat (5000) @(posedge clk);
        $display("[TB] FAIL watchdog: cycle budget exhausted");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic atNeg();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit r, input bit w, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        rd = r;
        wr = w;
        addr = a;
        wrData = d;
        tick();
        rd = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        checkEn = 1'b1;

        // Reset values.
        atNeg();
        checkOutput("reset busy", 128'(busy), 128'd1);
        checkOutput("reset app_en", 128'(appEn), 128'd0);
        checkOutput("reset wren", 128'(appWdfWren), 128'd0);
        checkOutput("reset done", 128'(done), 128'd0);
        checkOutput("reset rd_data", 128'(rdData), 128'd0);
        checkOutput("reset app_addr", 128'(appAddr), 128'd0);
        checkOutput("reset mask", 128'(appWdfMask), 128'd0);
        tick();
        resetn = 1'b1;
        tick();
        atNeg();
        checkOutput("idle busy", 128'(busy), 128'd0);

        // Write 0x12345678 to word 5, both channels ready.
        tick();
        appRdy = 1'b1;
        appWdfRdy = 1'b1;
        applyStimulus(1'b0, 1'b1, 26'd5, 32'h12345678);
        atNeg();
        checkOutput("wr1 app_en", 128'(appEn), 128'd1);
        checkOutput("wr1 app_addr", 128'(appAddr), 128'h10);
        checkOutput("wr1 app_cmd", 128'(appCmd), 128'd0);
        checkOutput("wr1 mask", 128'(appWdfMask), 128'hFF0F);
        checkOutput("wr1 data lane1", 128'(appWdfData[63:32]), 128'h12345678);
        tick();
        atNeg();
        checkOutput("wr1 done", 128'(done), 128'd1);
        checkOutput("wr1 en dropped", 128'(appEn), 128'd0);

        // Read word 7, line returned 20 cycles later.
        tick();
        appWdfRdy = 1'b0;
        applyStimulus(1'b1, 1'b0, 26'd7, 32'h0);
        atNeg();
        checkOutput("rd1 app_cmd", 128'(appCmd), 128'd1);
        checkOutput("rd1 app_addr", 128'(appAddr), 128'h10);
        tick();
        repeat (19) tick();
        appRdData = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        appRdDataValid = 1'b1;
        tick();
        appRdDataValid = 1'b0;
        atNeg();
        checkOutput("rd1 done", 128'(done), 128'd1);
        checkOutput("rd1 rd_data", 128'(rdData), 128'hDDDDDDDD);

        // Read word 9 with app_rdy held low for 10 cycles.
        tick();
        appRdy = 1'b0;
        applyStimulus(1'b1, 1'b0, 26'd9, 32'h0);
        for (int i = 0; i < 10; i++) begin
            atNeg();
            checkOutput("rd2 stall app_addr", 128'(appAddr), 128'h20);
            checkOutput("rd2 stall done", 128'(done), 128'd0);
            tick();
        end
        appRdy = 1'b1;
        tick();
        appRdData = 128'h44444444_33333333_22222222_11111111;
        appRdDataValid = 1'b1;
        tick();
        appRdDataValid = 1'b0;
        atNeg();
        checkOutput("rd2 rd_data", 128'(rdData), 128'h22222222);

        // Write word 2; data accepted three cycles before the command.
        tick();
        appRdy = 1'b0;
        applyStimulus(1'b0, 1'b1, 26'd2, 32'hCAFEBABE);
        appWdfRdy = 1'b1;
        atNeg();
        checkOutput("wr2 mask", 128'(appWdfMask), 128'hF0FF);
        tick();
        appWdfRdy = 1'b0;
        repeat (2) begin
            atNeg();
            checkOutput("wr2 wren low", 128'(appWdfWren), 128'd0);
            checkOutput("wr2 en held", 128'(appEn), 128'd1);
            tick();
        end
        appRdy = 1'b1;
        tick();
        appRdy = 1'b0;
        atNeg();
        checkOutput("wr2 done", 128'(done), 128'd1);
        tick();
        atNeg();
        checkOutput("wr2 single done", 128'(done), 128'd0);

        // Simultaneous rd and wr: the write wins.
        tick();
        appRdy = 1'b1;
        appWdfRdy = 1'b1;
        applyStimulus(1'b1, 1'b1, 26'd1, 32'h0BADF00D);
        atNeg();
        checkOutput("rdwr app_cmd", 128'(appCmd), 128'd0);
        checkOutput("rdwr wren", 128'(appWdfWren), 128'd1);
        tick();
        appWdfRdy = 1'b0;

        // Calibration low blocks new requests.
        tick();
        calibDone = 1'b0;
        applyStimulus(1'b1, 1'b0, 26'd4, 32'h0);
        atNeg();
        checkOutput("nocal busy", 128'(busy), 128'd1);
        checkOutput("nocal app_en", 128'(appEn), 128'd0);
        tick();
        calibDone = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b0, 26'd4, 32'h0);
        atNeg();
        checkOutput("cal rd app_addr", 128'(appAddr), 128'h10);
        tick();
        appRdData = 128'h44444444_33333333_22222222_11111111;
        appRdDataValid = 1'b1;
        tick();
        appRdDataValid = 1'b0;
        atNeg();
        checkOutput("cal rd rd_data", 128'(rdData), 128'h11111111);

        // Reset while waiting for read data, then a stale beat arrives.
        tick();
        applyStimulus(1'b1, 1'b0, 26'd6, 32'h0);
        tick();
        appRdy = 1'b0;
        resetn = 1'b0;
        tick();
        atNeg();
        checkOutput("abort app_en", 128'(appEn), 128'd0);
        checkOutput("abort busy", 128'(busy), 128'd1);
        checkOutput("abort rd_data", 128'(rdData), 128'd0);
        tick();
        resetn = 1'b1;
        appRdData = 128'hFFFFFFFF_EEEEEEEE_99999999_88888888;
        appRdDataValid = 1'b1;
        tick();
        appRdDataValid = 1'b0;
        atNeg();
        checkOutput("stale done", 128'(done), 128'd0);
        checkOutput("stale rd_data", 128'(rdData), 128'd0);
        repeat (3) tick();

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
